// File: rtl/jtag_dr_ctrl_if.sv
// System-side byte channels of the JTAG DR controller: host-to-system rx and system-to-host tx.
// master = system logic, slave = jtag_dr_ctrl.
interface jtag_dr_ctrl_if;
    logic       rx_valid_o;
    logic [7:0] rx_data_o;
    logic       rx_ready_i;
    logic       tx_valid_i;
    logic [7:0] tx_data_i;
    logic       tx_ready_o;

    modport master (
        input  rx_valid_o, rx_data_o, tx_ready_o,
        output rx_ready_i, tx_valid_i, tx_data_i
    );

    modport slave (
        output rx_valid_o, rx_data_o, tx_ready_o,
        input  rx_ready_i, tx_valid_i, tx_data_i
    );
endinterface

// File: rtl/jtag_dr_ctrl.sv
// Oversamples the virtual-JTAG DR path, runs an 11-bit shift register and trades bytes with the system.
// Actions land g_sync_stages+1 clocks after a tck rise; rx/tx are one-entry buffers with valid/ready.
module jtag_dr_ctrl #(
    parameter int g_sync_stages = 2
) (
    input  logic         clk_sys_i,
    input  logic         rst_n_i,
    input  logic         tck_i,
    input  logic         tdi_i,
    input  logic         capture_i,
    input  logic         shift_i,
    input  logic         update_i,
    output logic         tdo_o,
    output logic         overrun_o,
    input  logic         clr_overrun_i,
    output logic         jtag_rst_o,
    jtag_dr_ctrl_if.slave sys
);

    // Bit order inside each synchronizer stage: {update, shift, capture, tdi, tck}.
    logic [g_sync_stages-1:0][4:0] sync_q, sync_d;
    logic        tck_prev_q, tck_prev_d;
    logic        armed_q, armed_d;
    logic [10:0] sr_q, sr_d;
    logic        tdo_q, tdo_d;
    logic        tx_snap_q, tx_snap_d;
    logic        rx_full_q, rx_full_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        tx_full_q, tx_full_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        overrun_q, overrun_d;
    logic        jtag_rst_q, jtag_rst_d;

    logic [4:0]  tap_s;
    logic        tck_edge, do_cap, do_shift, do_upd;
    logic        host_wr, host_ack, rx_take, rx_free, tx_load;
    logic [2:0]  cmd;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {update_i, shift_i, capture_i, tdi_i, tck_i};
        for (int i = 1; i < g_sync_stages; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        tap_s      = sync_q[g_sync_stages-1];
        tck_prev_d = tap_s[0];
        // Edges count only once tck has been seen low, so a tck held high through reset is not an edge.
        armed_d    = armed_q | ~tap_s[0];
        tck_edge   = armed_q & tap_s[0] & ~tck_prev_q;
        do_cap     = tck_edge & tap_s[2];
        do_shift   = tck_edge & ~tap_s[2] & tap_s[3];
        do_upd     = tck_edge & ~tap_s[2] & ~tap_s[3] & tap_s[4];
        cmd        = sr_q[10:8];
        host_wr    = do_upd & ((cmd == 3'b001) | (cmd == 3'b011));
        host_ack   = do_upd & ((cmd == 3'b010) | (cmd == 3'b011));
        rx_take    = rx_full_q & sys.rx_ready_i;
        rx_free    = ~rx_full_q | rx_take;
        tx_load    = sys.tx_valid_i & ~tx_full_q;
    end

    always_comb begin
        sr_d       = sr_q;
        tdo_d      = sr_q[0];
        tx_snap_d  = tx_snap_q;
        rx_full_d  = rx_full_q;
        rx_data_d  = rx_data_q;
        tx_full_d  = tx_full_q;
        tx_byte_d  = tx_byte_q;
        overrun_d  = overrun_q;
        jtag_rst_d = do_upd & (cmd == 3'b100);

        if (do_cap) begin
            sr_d      = {1'b0, rx_full_q, tx_full_q, tx_byte_q};
            tx_snap_d = tx_full_q;
        end else if (do_shift) begin
            sr_d = {tap_s[1], sr_q[10:1]};
        end

        if (rx_take) begin
            rx_full_d = 1'b0;
        end
        if (host_wr && rx_free) begin
            rx_full_d = 1'b1;
            rx_data_d = sr_q[7:0];
        end

        if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
        if (host_wr && !rx_free) begin
            overrun_d = 1'b1;
        end

        // Ack only releases a byte that was already held when the host captured.
        if (tx_load) begin
            tx_full_d = 1'b1;
            tx_byte_d = sys.tx_data_i;
        end else if (host_ack && tx_snap_q) begin
            tx_full_d = 1'b0;
        end
        if (host_ack) begin
            tx_snap_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q     <= '0;
            tck_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            sr_q       <= '0;
            tdo_q      <= 1'b0;
            tx_snap_q  <= 1'b0;
            rx_full_q  <= 1'b0;
            rx_data_q  <= '0;
            tx_full_q  <= 1'b0;
            tx_byte_q  <= '0;
            overrun_q  <= 1'b0;
            jtag_rst_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            tck_prev_q <= tck_prev_d;
            armed_q    <= armed_d;
            sr_q       <= sr_d;
            tdo_q      <= tdo_d;
            tx_snap_q  <= tx_snap_d;
            rx_full_q  <= rx_full_d;
            rx_data_q  <= rx_data_d;
            tx_full_q  <= tx_full_d;
            tx_byte_q  <= tx_byte_d;
            overrun_q  <= overrun_d;
            jtag_rst_q <= jtag_rst_d;
        end
    end

    assign tdo_o          = tdo_q;
    assign overrun_o      = overrun_q;
    assign jtag_rst_o     = jtag_rst_q;
    assign sys.rx_valid_o = rx_full_q;
    assign sys.rx_data_o  = rx_data_q;
    assign sys.tx_ready_o = ~tx_full_q;

endmodule

// File: tb/tb_jtag_dr_ctrl.sv
// Bench for jtag_dr_ctrl: table of host DR transactions plus hand-written corner sequences.
module tb_jtag_dr_ctrl;
    localparam int G    = 2;
    localparam int HALF = 6;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    logic tck = 1'b0, tdi = 1'b0, cap = 1'b0, sh = 1'b0, upd = 1'b0;
    logic tdo, overrun, clr_overrun = 1'b0, jtag_rst;

    jtag_dr_ctrl_if bus();

    jtag_dr_ctrl #(.g_sync_stages(G)) dut (
        .clk_sys_i    (clk_sys),
        .rst_n_i      (rst_n),
        .tck_i        (tck),
        .tdi_i        (tdi),
        .capture_i    (cap),
        .shift_i      (sh),
        .update_i     (upd),
        .tdo_o        (tdo),
        .overrun_o    (overrun),
        .clr_overrun_i(clr_overrun),
        .jtag_rst_o   (jtag_rst),
        .sys          (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int rst_pulses = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic        ld;
        logic [7:0]  tx_b;
        logic [2:0]  cmd;
        logic [7:0]  dat;
        logic [10:0] exp_cap;
        logic        exp_tx_rdy;
        int          exp_rst;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: host writes push the expected byte, each rx handshake pops one.
    always @(negedge clk_sys) begin
        if (bus.rx_valid_o && bus.rx_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got 0x%0h expected no byte", bus.rx_data_o);
            end else begin
                chk("rx_byte", {24'h0, bus.rx_data_o}, {24'h0, exp_q.pop_front()});
            end
        end
        if (jtag_rst) rst_pulses++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic tap_pulse(input logic c, input logic s, input logic u, input logic d);
        cap = c; sh = s; upd = u; tdi = d;
        clks(HALF);
        tck = 1'b1;
        clks(HALF);
        tck = 1'b0;
        cap = 1'b0; sh = 1'b0; upd = 1'b0;
    endtask

    task automatic dr_shift(input logic [10:0] din, output logic [10:0] dout);
        for (int i = 0; i < 11; i++) begin
            dout[i] = tdo;
            tap_pulse(1'b0, 1'b1, 1'b0, din[i]);
        end
    endtask

    task automatic dr_xfer(input logic [10:0] din, output logic [10:0] dout);
        tap_pulse(1'b1, 1'b0, 1'b0, 1'b0);
        dr_shift(din, dout);
        tap_pulse(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic tx_send(input logic [7:0] b);
        int n = 0;
        while (!bus.tx_ready_o && n < 100) begin
            clks(1);
            n++;
        end
        if (n == 100) begin
            checks++;
            errors++;
            $display("FAIL tx_ready_wait: got tx_ready=0 for 100 cycles expected 1");
        end
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = b;
        clks(1);
        bus.tx_valid_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] dout;
        bus.rx_ready_i = 1'b0;
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = 8'h00;

        tbl[0] = '{1'b0, 8'h00, 3'b000, 8'h00, 11'h000, 1'b1, 0};
        tbl[1] = '{1'b0, 8'h00, 3'b001, 8'hA5, 11'h000, 1'b1, 0};
        tbl[2] = '{1'b1, 8'h5A, 3'b010, 8'h00, 11'h15A, 1'b1, 0};
        tbl[3] = '{1'b0, 8'h00, 3'b011, 8'h3C, 11'h05A, 1'b1, 0};
        tbl[4] = '{1'b0, 8'h00, 3'b100, 8'h00, 11'h05A, 1'b1, 1};
        tbl[5] = '{1'b1, 8'hC3, 3'b001, 8'h7E, 11'h1C3, 1'b0, 0};
        tbl[6] = '{1'b0, 8'h00, 3'b010, 8'h00, 11'h1C3, 1'b1, 0};
        tbl[7] = '{1'b0, 8'h00, 3'b111, 8'hFF, 11'h0C3, 1'b1, 0};

        // Reset state
        clks(3);
        rst_n = 1'b1;
        clks(3);
        chk("rst_tdo",      {31'h0, tdo}, 32'h0);
        chk("rst_rx_valid", {31'h0, bus.rx_valid_o}, 32'h0);
        chk("rst_rx_data",  {24'h0, bus.rx_data_o}, 32'h0);
        chk("rst_tx_ready", {31'h0, bus.tx_ready_o}, 32'h1);
        chk("rst_overrun",  {31'h0, overrun}, 32'h0);
        chk("rst_jtag_rst", {31'h0, jtag_rst}, 32'h0);

        // Table of host transactions, system always draining rx
        bus.rx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].ld) tx_send(tbl[i].tx_b);
            if (tbl[i].cmd == 3'b001 || tbl[i].cmd == 3'b011) exp_q.push_back(tbl[i].dat);
            rst_pulses = 0;
            dr_xfer({tbl[i].cmd, tbl[i].dat}, dout);
            clks(10);
            chk($sformatf("tbl%0d_capture", i), {21'h0, dout}, {21'h0, tbl[i].exp_cap});
            chk($sformatf("tbl%0d_tx_ready", i), {31'h0, bus.tx_ready_o}, {31'h0, tbl[i].exp_tx_rdy});
            chk($sformatf("tbl%0d_rst_pulses", i), rst_pulses, tbl[i].exp_rst);
            chk($sformatf("tbl%0d_overrun", i), {31'h0, overrun}, 32'h0);
        end
        chk("tbl_queue_drained", exp_q.size(), 0);

        // Update-to-rx_valid latency and single-cycle consumption
        bus.rx_ready_i = 1'b0;
        exp_q.push_back(8'hA5);
        dr_shift({3'b001, 8'hA5}, dout);
        upd = 1'b1;
        clks(HALF);
        tck = 1'b1;
        clks(G + 2);
        chk("lat_rx_valid", {31'h0, bus.rx_valid_o}, 32'h1);
        chk("lat_rx_data",  {24'h0, bus.rx_data_o}, 32'hA5);
        clks(HALF - (G + 2));
        tck = 1'b0;
        upd = 1'b0;
        clks(HALF);
        bus.rx_ready_i = 1'b1;
        clks(1);
        bus.rx_ready_i = 1'b0;
        chk("rx_consumed", {31'h0, bus.rx_valid_o}, 32'h0);

        // Overrun: second write dropped while first unread
        exp_q.push_back(8'h11);
        dr_xfer({3'b001, 8'h11}, dout);
        dr_xfer({3'b001, 8'h22}, dout);
        clks(4);
        chk("ovr_rx_data", {24'h0, bus.rx_data_o}, 32'h11);
        chk("ovr_flag",    {31'h0, overrun}, 32'h1);
        clr_overrun = 1'b1;
        clks(1);
        clr_overrun = 1'b0;
        chk("ovr_cleared", {31'h0, overrun}, 32'h0);
        bus.rx_ready_i = 1'b1;
        clks(3);
        chk("ovr_drained", exp_q.size(), 0);
        chk("ovr_rx_valid", {31'h0, bus.rx_valid_o}, 32'h0);

        // Byte loaded after capture survives an ack
        tap_pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tx_send(8'h77);
        dr_shift({3'b010, 8'h00}, dout);
        tap_pulse(1'b0, 1'b0, 1'b1, 1'b0);
        clks(4);
        chk("stale_ack_tx_ready", {31'h0, bus.tx_ready_o}, 32'h0);
        dr_xfer({3'b000, 8'h00}, dout);
        chk("stale_ack_capture", {21'h0, dout}, 32'h177);
        dr_xfer({3'b010, 8'h00}, dout);
        clks(4);
        chk("ack_tx_ready", {31'h0, bus.tx_ready_o}, 32'h1);

        // Reset in the middle of a shift with both buffers occupied
        bus.rx_ready_i = 1'b0;
        tx_send(8'h44);
        dr_xfer({3'b001, 8'h33}, dout);
        tap_pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tap_pulse(1'b0, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        clks(2);
        rst_n = 1'b1;
        clks(3);
        chk("mid_rst_tdo",      {31'h0, tdo}, 32'h0);
        chk("mid_rst_rx_valid", {31'h0, bus.rx_valid_o}, 32'h0);
        chk("mid_rst_rx_data",  {24'h0, bus.rx_data_o}, 32'h0);
        chk("mid_rst_tx_ready", {31'h0, bus.tx_ready_o}, 32'h1);
        chk("mid_rst_overrun",  {31'h0, overrun}, 32'h0);
        bus.rx_ready_i = 1'b1;
        exp_q.push_back(8'h96);
        dr_xfer({3'b001, 8'h96}, dout);
        clks(6);
        chk("post_rst_capture", {21'h0, dout}, 32'h000);
        chk("final_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
